// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: memory request/response and decode-side
// signals of the prefetching fetch unit.
interface ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid_o;
  logic            req_ready_i;
  logic [XLEN-1:0] req_addr_o;
  logic            rsp_valid_i;
  logic [31:0]     rsp_data_i;
  logic            inst_valid_o;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] pc_o;
  logic            id_ready_i;
  logic            jump_req_i;
  logic [XLEN-1:0] jump_pc_i;
  logic            excp_jump_req_i;
  logic [XLEN-1:0] excp_jump_pc_i;

  modport master (
    output req_valid_o,
    input  req_ready_i,
    output req_addr_o,
    input  rsp_valid_i,
    input  rsp_data_i,
    output inst_valid_o,
    output inst_o,
    output pc_o,
    input  id_ready_i,
    input  jump_req_i,
    input  jump_pc_i,
    input  excp_jump_req_i,
    input  excp_jump_pc_i
  );

  modport slave (
    input  req_valid_o,
    output req_ready_i,
    input  req_addr_o,
    output rsp_valid_i,
    output rsp_data_i,
    input  inst_valid_o,
    input  inst_o,
    input  pc_o,
    output id_ready_i,
    output jump_req_i,
    output jump_pc_i,
    output excp_jump_req_i,
    output excp_jump_pc_i
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-based prefetching fetch unit with a
// DEPTH-entry {pc, inst} queue and wrong-path response drop.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifu_prefetch_if.master       bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [31:0]     r_q_inst [DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_inflight;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_inst_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_rsp;

  assign w_rsp      = bus.rsp_valid_i;
  assign w_redirect = bus.excp_jump_req_i | bus.jump_req_i;
  assign w_target   = bus.excp_jump_req_i ? bus.excp_jump_pc_i
                                          : bus.jump_pc_i;
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid = !w_redirect && (w_inflight < LP_DEPTH);
  assign w_req_fire  = w_req_valid && bus.req_ready_i;
  assign w_inst_valid = (r_count != '0) && !w_redirect;
  assign w_pop  = w_inst_valid && bus.id_ready_i;
  assign w_push = w_rsp && (r_drop_cnt == '0) && !w_redirect;

  assign bus.req_valid_o  = w_req_valid;
  assign bus.req_addr_o   = r_fetch_pc;
  assign bus.inst_valid_o = w_inst_valid;
  assign bus.inst_o = w_inst_valid ? r_q_inst[r_rd_ptr] : NOP;
  assign bus.pc_o   = w_inst_valid ? r_q_pc[r_rd_ptr] : '0;

  // Fetch and response PC tracking; both jump on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_ADDR;
      r_rsp_pc   <= RESET_ADDR;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_rsp_pc   <= w_target;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(4);
    end
  end

  // Requests in flight, and how many of them are wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire)
                     - CW'(w_rsp);
      if (w_redirect)
        r_drop_cnt <= r_outstanding - CW'(w_rsp);
      else if (w_rsp && r_drop_cnt != '0)
        r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  // Queue occupancy and pointers; redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (w_redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CW'(1);
        (w_pop && !w_push): r_count <= r_count - CW'(1);
        default:            r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
      r_q_inst[r_wr_ptr] <= bus.rsp_data_i;
    end
  end

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_rsp && r_outstanding == '0));

  a_credit: assert property (
    @(posedge clk) disable iff (!rst_n)
    w_inflight <= LP_DEPTH);

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed steps with a latency-programmable
// memory model and an expected-PC scoreboard.
module tb_ifu_prefetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.XLEN(32)) bus ();
  ifu_prefetch_if #(.XLEN(32)) bus2 ();

  ifu_prefetch #(
    .XLEN(32), .DEPTH(4), .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ifu_prefetch #(
    .XLEN(32), .DEPTH(4), .RESET_ADDR(32'hFFFF_FFF8)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] sb_pc[$];
  logic [31:0] exp_fetch;
  logic [31:0] first_pc;
  logic        got_first;
  int checks = 0;
  int errors = 0;
  int cyc, lat, pops, reqs;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic redir;
    logic [31:0] p;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_data_i  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.rsp_valid_i = 1'b1;
      bus.rsp_data_i  = hashf(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    redir = bus.excp_jump_req_i | bus.jump_req_i;
    if (redir) begin
      chk("redir_req_valid", 32'(bus.req_valid_o), 32'd0);
      chk("redir_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    end
    if (bus.req_valid_o && bus.req_ready_i) begin
      chk("req_addr", bus.req_addr_o, exp_fetch);
      mq.push_back('{addr: bus.req_addr_o, due: cyc + lat});
      sb_pc.push_back(exp_fetch);
      exp_fetch += 32'd4;
      reqs++;
    end
    if (bus.inst_valid_o && bus.id_ready_i) begin
      if (sb_pc.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL pop_unexpected observed pc=%h expected none",
               bus.pc_o);
      end else begin
        p = sb_pc.pop_front();
        chk("pop_pc", bus.pc_o, p);
        chk("pop_inst", bus.inst_o, hashf(p));
        if (!got_first) begin
          got_first = 1'b1;
          first_pc  = bus.pc_o;
        end
      end
      pops++;
    end
    if (redir) begin
      sb_pc.delete();
      exp_fetch = bus.excp_jump_req_i ? bus.excp_jump_pc_i
                                      : bus.jump_pc_i;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_ready_i     = 1'b1;
    bus.rsp_valid_i     = 1'b0;
    bus.rsp_data_i      = '0;
    bus.id_ready_i      = 1'b1;
    bus.jump_req_i      = 1'b0;
    bus.jump_pc_i       = '0;
    bus.excp_jump_req_i = 1'b0;
    bus.excp_jump_pc_i  = '0;
    mq.delete();
    sb_pc.delete();
    exp_fetch = 32'h0;
    got_first = 1'b0;
    first_pc  = 32'hFFFF_FFFF;
    cyc = 0; pops = 0; reqs = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus2.req_ready_i     = 1'b1;
    bus2.rsp_valid_i     = 1'b0;
    bus2.rsp_data_i      = '0;
    bus2.id_ready_i      = 1'b0;
    bus2.jump_req_i      = 1'b0;
    bus2.jump_pc_i       = '0;
    bus2.excp_jump_req_i = 1'b0;
    bus2.excp_jump_pc_i  = '0;
    lat = 1;
    do_reset();
    #1;
    chk("rst_req_valid", 32'(bus.req_valid_o), 32'd1);
    chk("rst_req_addr", bus.req_addr_o, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst_nop", bus.inst_o, 32'h0000_0013);
    chk("rst_pc_zero", bus.pc_o, 32'h0);
    chk("wrap_addr0", bus2.req_addr_o, 32'hFFFF_FFF8);

    // streaming, 1-cycle memory; wrap instance alongside
    tick();
    chk("wrap_addr1", bus2.req_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", bus2.req_addr_o, 32'h0000_0000);
    chk("first_valid_c2", 32'(bus.inst_valid_o), 32'd1);
    chk("first_pc_c2", bus.pc_o, 32'h0);
    tick();
    chk("wrap_addr3", bus2.req_addr_o, 32'h0000_0004);
    tick();
    chk("wrap_credit_stop", 32'(bus2.req_valid_o), 32'd0);
    repeat (18) tick();
    chk("stream_pops", 32'(pops), 32'd20);
    chk("stream_reqs", 32'(reqs), 32'd22);

    // decode stalled: queue fills, credits run out
    do_reset();
    lat = 1;
    bus.id_ready_i = 1'b0;
    repeat (8) tick();
    chk("stall_reqs", 32'(reqs), 32'd4);
    chk("stall_req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("stall_count", 32'(dut.r_count), 32'd4);
    bus.id_ready_i = 1'b1;
    repeat (8) tick();
    chk("resume_pops", 32'(pops), 32'd8);
    chk("resume_reqs", 32'(reqs), 32'd11);

    // 3 in flight, jump with no response that cycle
    do_reset();
    lat = 4;
    repeat (3) tick();
    bus.jump_req_i = 1'b1;
    bus.jump_pc_i  = 32'h100;
    tick();
    bus.jump_req_i = 1'b0;
    chk("jump_drop_cnt", 32'(dut.r_drop_cnt), 32'd3);
    chk("jump_next_addr", bus.req_addr_o, 32'h100);
    repeat (14) tick();
    chk("jump_first_pc", first_pc, 32'h100);

    // response arriving in the redirect cycle
    do_reset();
    lat = 3;
    repeat (3) tick();
    bus.jump_req_i = 1'b1;
    bus.jump_pc_i  = 32'h40;
    tick();
    bus.jump_req_i = 1'b0;
    chk("rsp_redir_drop", 32'(dut.r_drop_cnt), 32'd2);
    chk("rsp_redir_count", 32'(dut.r_count), 32'd0);
    repeat (12) tick();
    chk("rsp_redir_first", first_pc, 32'h40);

    // exception beats jump, full queue flushed
    do_reset();
    lat = 1;
    bus.id_ready_i = 1'b0;
    repeat (6) tick();
    chk("prio_full", 32'(bus.inst_valid_o), 32'd1);
    bus.jump_req_i      = 1'b1;
    bus.jump_pc_i       = 32'h200;
    bus.excp_jump_req_i = 1'b1;
    bus.excp_jump_pc_i  = 32'h80;
    tick();
    bus.jump_req_i      = 1'b0;
    bus.excp_jump_req_i = 1'b0;
    chk("prio_count", 32'(dut.r_count), 32'd0);
    chk("prio_addr", bus.req_addr_o, 32'h80);
    bus.id_ready_i = 1'b1;
    repeat (10) tick();
    chk("prio_first_pc", first_pc, 32'h80);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised prefetching instruction fetch unit, the successor of the single-register fetch stage. It sits between the instruction memory port and the decode stage. It issues pipelined, in-order fetch requests with a valid/ready handshake and buffers returned instructions with their PCs in a DEPTH-entry queue. It redirects on branch/jump and exception requests, with exception having priority, and discards wrong-path responses still in flight.

## Interface

Parameters:
- XLEN, 32: PC/address width.
- DEPTH, 4: queue entries and maximum outstanding requests; power of 2, ≥2.
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  memory accepts the request this cycle.
- req_addr_o  out  XLEN  fetch address.
- rsp_valid_i  in  1  instruction returned; responses arrive in request order, at least 1 cycle after acceptance.
- rsp_data_i  in  32  returned instruction.
- inst_valid_o  out  1  queue head valid for decode.
- inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when inst_valid_o=0.
- pc_o  out  XLEN  head PC; 0 when inst_valid_o=0.
- id_ready_i  in  1  decode consumes the head this cycle (inverse of stall).
- jump_req_i  in  1  branch/jump redirect from decode.
- jump_pc_i  in  XLEN  jump target.
- excp_jump_req_i  in  1  exception/interrupt redirect.
- excp_jump_pc_i  in  XLEN  trap target.

## Operation

- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next kept response.
  - Queue of {pc, inst}, with count (clog2(DEPTH)+1 bits).
  - outstanding: accepted requests not yet answered, same width.
  - drop_cnt: responses still to discard, same width.
- redirect = excp_jump_req_i | jump_req_i. target = excp_jump_pc_i if excp_jump_req_i, else jump_pc_i.
- Credit rule: req_valid_o = !redirect & (count + outstanding < DEPTH). req_addr_o = fetch_pc. The invariant count + outstanding ≤ DEPTH must hold at all times.
- Request handshake (req_valid_o & req_ready_i):
  - fetch_pc += 4, modulo 2^XLEN, wrapping silently.
  - outstanding += 1.
- Response (rsp_valid_i):
  - outstanding -= 1.
  - If drop_cnt > 0 or redirect: discard and decrement drop_cnt (saturating at 0).
  - Otherwise: push {rsp_pc, rsp_data_i}; rsp_pc += 4.
  - A push can never overflow because of the credit rule. Assertion: no rsp_valid_i when outstanding = 0.
- Pop: inst_valid_o & id_ready_i. inst_valid_o = (count ≠ 0) & !redirect.
- Redirect cycle:
  - Queue flushed (count ← 0).
  - fetch_pc ← target; rsp_pc ← target.
  - drop_cnt ← outstanding − rsp_valid_i, i.e. every older request still in flight.
  - No request issued, no pop, no push.
  - Exception wins when both redirects are asserted.
- Simultaneous push and pop: count unchanged.
- Pop with an empty queue is ignored.

## Timing

- Reset values:
  - fetch_pc = rsp_pc = RESET_ADDR.
  - count = outstanding = drop_cnt = 0.
  - Resulting outputs: req_valid_o=1, req_addr_o=RESET_ADDR, inst_valid_o=0, inst_o=NOP, pc_o=0.
- Latency: request accepted in cycle n, response in cycle n+k (k ≥ 1), instruction visible at the queue head in cycle n+k+1. There is no response-to-output bypass.
- Throughput: 1 instruction/cycle sustained when memory answers every cycle and decode is ready.
- Redirect to first new request: the request for target is issued the cycle after redirect.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight responses after reset release are the memory's responsibility to squash.
- req_valid_o, inst_valid_o, inst_o and pc_o are combinational from registered state and the redirect inputs. No input-to-output path exists through req_ready_i or id_ready_i.

## Test plan

- Reset release, memory always ready with 1-cycle response, id_ready_i=1: requests at addresses 0, 4, 8, …. The first inst_valid_o appears in cycle 2 with pc_o=0, followed by one instruction per cycle.
- id_ready_i=0 with DEPTH=4: exactly 4 requests are issued, then req_valid_o=0 and count=4. Restore ready: 4 pops in order with pc 0, 4, 8, 12, and requests resume at 16.
- Memory with 3-cycle response latency and 3 outstanding requests; jump_req_i with target 0x100 issued. The 3 stale responses are discarded, the next request address is 0x100, and the first delivered pc_o is 0x100.
- jump_req_i (0x200) and excp_jump_req_i (0x80) in the same cycle: redirect goes to 0x80. The queue is empty and inst_valid_o=0 in that cycle.
- Response arriving in the redirect cycle: it is dropped, and drop_cnt equals outstanding−1.
- RESET_ADDR = 0xFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, wrapping without error.
